counter_share_arbiter: RTL and testbench

//   Shares one CW-bit up counter between NREQ requesters on a round-robin basis.

---
 rtl/counter_share_arbiter_if.sv | 23 ++
 rtl/counter_share_arbiter.sv | 144 ++++++++++++++
 tb/tb_counter_share_arbiter.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/counter_share_arbiter_if.sv
// Request/grant bundle between the shared counter arbiter and its clients.
// Clients drive req/len; the arbiter returns ownership, count and completion.
interface counter_share_arbiter_if #(
    parameter int NREQ = 4,
    parameter int CW   = 4
);
    logic [NREQ-1:0]    req;
    logic [NREQ*CW-1:0] len;
    logic [NREQ-1:0]    grant;
    logic               busy;
    logic [CW-1:0]      Q;
    logic [NREQ-1:0]    done;

    modport master (
        output req, len,
        input  grant, busy, Q, done
    );

    modport slave (
        input  req, len,
        output grant, busy, Q, done
    );
endinterface

// File: rtl/counter_share_arbiter.sv
// Round-robin owner of one shared up counter; the winner's counter runs
// from 0 to its latched length, then a done pulse hands the counter back.
module counter_share_arbiter #(
    parameter int NREQ = 4,
    parameter int CW   = 4
) (
    input  logic                    clk,
    input  logic                    clear,
    counter_share_arbiter_if.slave  bus
);
    localparam int IW = $clog2(NREQ);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COUNT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [IW-1:0]   r_rr;
    logic [IW-1:0]   r_win;
    logic [CW-1:0]   r_term;
    logic [CW-1:0]   r_q;
    logic [NREQ-1:0] r_grant;
    logic [NREQ-1:0] r_done;

    logic [IW-1:0]   w_rr_nxt;
    logic [IW-1:0]   w_win_nxt;
    logic [CW-1:0]   w_term_nxt;
    logic [CW-1:0]   w_q_nxt;
    logic [NREQ-1:0] w_grant_nxt;
    logic [NREQ-1:0] w_done_nxt;

    logic [IW-1:0]   w_pick;
    logic            w_any;
    logic [IW-1:0]   w_win_inc;
    logic            w_hold;
    logic            w_last;
    logic [NREQ-1:0] w_one;

    assign w_one     = {{(NREQ-1){1'b0}}, 1'b1};
    assign w_win_inc = (r_win == IW'(NREQ-1)) ? '0 : r_win + 1'b1;
    assign w_hold    = bus.req[r_win];
    assign w_last    = (r_q == r_term);

    // First active requester at or after the rr pointer, wrapping.
    always_comb begin : p_pick
        int idx;
        idx    = 0;
        w_any  = 1'b0;
        w_pick = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(r_rr) + i) % NREQ;
            if (!w_any && bus.req[idx]) begin
                w_any  = 1'b1;
                w_pick = IW'(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            r_state <= S_IDLE;
            r_rr    <= '0;
            r_win   <= '0;
            r_term  <= '0;
            r_q     <= '0;
            r_grant <= '0;
            r_done  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_rr    <= w_rr_nxt;
            r_win   <= w_win_nxt;
            r_term  <= w_term_nxt;
            r_q     <= w_q_nxt;
            r_grant <= w_grant_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_state_nxt = S_COUNT;
                end
            end
            S_COUNT: begin
                if (!w_hold) begin
                    w_state_nxt = S_IDLE;
                end else if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Registered outputs: the counter never steps past the latched term.
    always_comb begin
        w_rr_nxt    = r_rr;
        w_win_nxt   = r_win;
        w_term_nxt  = r_term;
        w_q_nxt     = r_q;
        w_grant_nxt = r_grant;
        w_done_nxt  = '0;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_win_nxt   = w_pick;
                    w_term_nxt  = bus.len[int'(w_pick)*CW +: CW];
                    w_grant_nxt = w_one << w_pick;
                    w_q_nxt     = '0;
                end
            end
            S_COUNT: begin
                if (!w_hold) begin
                    w_grant_nxt = '0;
                    w_q_nxt     = '0;
                    w_rr_nxt    = w_win_inc;
                end else if (w_last) begin
                    w_done_nxt  = w_one << r_win;
                    w_grant_nxt = '0;
                    w_q_nxt     = '0;
                    w_rr_nxt    = w_win_inc;
                end else begin
                    w_q_nxt = r_q + 1'b1;
                end
            end
            default: begin
                w_grant_nxt = '0;
            end
        endcase
    end

    assign bus.grant = r_grant;
    assign bus.done  = r_done;
    assign bus.Q     = r_q;
    assign bus.busy  = (r_state == S_COUNT) || (r_state == S_DONE);

endmodule

// File: tb/tb_counter_share_arbiter.sv
// Randomized scoreboard bench: a transaction-level arbitration model
// predicts each grant episode; a negedge monitor checks what the DUT shows.
module tb_counter_share_arbiter;
    localparam int N  = 4;
    localparam int CW = 4;

    logic clk;
    logic clear;

    counter_share_arbiter_if #(.NREQ(N), .CW(CW)) bus ();

    counter_share_arbiter #(.NREQ(N), .CW(CW)) dut (
        .clk   (clk),
        .clear (clear),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int win;
        int term;
        bit cut;
        int cutq;
        int gap;
    } ep_t;

    ep_t sb[$];
    int  n_chk;
    int  n_pass;
    int  rr_m;
    bit  mon_en;
    bit  in_ep;
    int  cyc;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Arbitration model: pending requesters are served in rr order,
    // each grant moving the pointer just past the winner.
    task automatic build(input logic [N-1:0] mask, input logic [N*CW-1:0] lens,
                         input int aw, input int cutq, input bit uc);
        logic [N-1:0] pend;
        int  w;
        int  ng;
        bit  first;
        ep_t e;
        pend  = mask;
        first = 1'b1;
        ng    = 0;
        while (pend != '0) begin
            w = -1;
            for (int k = 0; k < N; k++) begin
                if (w < 0 && pend[(rr_m + k) % N]) w = (rr_m + k) % N;
            end
            e.win  = w;
            e.term = int'(lens[w*CW +: CW]);
            e.cut  = (w == aw);
            e.cutq = cutq;
            e.gap  = first ? 0 : ng;
            ng     = e.cut ? cutq + 2 : e.term + 3;
            sb.push_back(e);
            pend[w] = 1'b0;
            first   = 1'b0;
            if (e.cut && uc) begin
                rr_m = 0;
                break;
            end
            rr_m = (w + 1) % N;
        end
    endtask

    task automatic run_batch(input logic [N-1:0] mask, input logic [N*CW-1:0] lens,
                             input int aw, input int cutq, input bit uc);
        logic [N-1:0] prev;
        bit  cutdone;
        int  n;
        build(mask, lens, aw, cutq, uc);
        bus.len = lens;
        bus.req = mask;
        prev    = '0;
        cutdone = 1'b0;
        n       = 0;
        while (n < 600) begin
            tick();
            n++;
            clear   = 1'b0;
            bus.req = bus.req & ~prev;
            prev    = bus.done;
            if (aw >= 0 && !cutdone && bus.grant[aw] && int'(bus.Q) == cutq) begin
                cutdone = 1'b1;
                if (uc) begin
                    clear   = 1'b1;
                    bus.req = '0;
                end else begin
                    bus.req[aw] = 1'b0;
                end
            end
            if (bus.req == '0 && sb.size() == 0 && !in_ep && !clear) break;
        end
        if (n >= 600) chk("batch_timeout", 1, 0);
    endtask

    int   st;
    ep_t  cur;
    int   k;

    always @(negedge clk) begin
        cyc++;
        if (mon_en) begin
            if (!in_ep) begin
                if (bus.grant != '0) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_grant", int'(bus.grant), 0);
                    end else begin
                        cur = sb.pop_front();
                        chk("grant_onehot", int'(bus.grant), 1 << cur.win);
                        chk("q_start", int'(bus.Q), 0);
                        if (cur.gap != 0) chk("grant_gap", cyc - st, cur.gap);
                        st    = cyc;
                        k     = 1;
                        in_ep = 1'b1;
                    end
                end else begin
                    chk("idle_done", int'(bus.done), 0);
                end
            end else if (bus.grant != '0) begin
                chk("grant_hold", int'(bus.grant), 1 << cur.win);
                chk("q_count", int'(bus.Q), k);
                chk("busy_count", int'(bus.busy), 1);
                k++;
            end else begin
                chk("q_end", int'(bus.Q), 0);
                if (cur.cut) begin
                    chk("cut_done", int'(bus.done), 0);
                    chk("cut_len", k, cur.cutq + 1);
                    chk("cut_busy", int'(bus.busy), 0);
                end else begin
                    chk("done_pulse", int'(bus.done), 1 << cur.win);
                    chk("count_len", k, cur.term + 1);
                    chk("done_busy", int'(bus.busy), 1);
                end
                in_ep = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0]    m;
        logic [N*CW-1:0] l;
        int aw;
        int cq;
        n_chk   = 0;
        n_pass  = 0;
        rr_m    = 0;
        mon_en  = 1'b0;
        in_ep   = 1'b0;
        cyc     = 0;
        st      = 0;
        clear   = 1'b1;
        bus.req = '1;
        bus.len = '1;
        tick();
        tick();
        chk("rst_grant", int'(bus.grant), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_q", int'(bus.Q), 0);
        clear   = 1'b0;
        bus.req = '0;
        mon_en  = 1'b1;
        tick();

        run_batch(4'b0001, 16'h0003, -1, 0, 1'b0);
        run_batch(4'b1111, 16'h1111, -1, 0, 1'b0);
        run_batch(4'b1111, 16'h1111, -1, 0, 1'b0);
        run_batch(4'b0001, 16'h0000, -1, 0, 1'b0);
        run_batch(4'b0010, 16'h00F0, -1, 0, 1'b0);
        run_batch(4'b1000, 16'hF000, -1, 0, 1'b0);
        run_batch(4'b0011, 16'h0047, 0, 2, 1'b0);
        run_batch(4'b0001, 16'h0009, 0, 5, 1'b1);
        run_batch(4'b1111, 16'h2130, -1, 0, 1'b0);

        for (int b = 0; b < 40; b++) begin
            m  = N'($urandom_range(1, (1 << N) - 1));
            l  = (N*CW)'($urandom);
            aw = -1;
            cq = 0;
            if ($urandom_range(0, 3) == 0) begin
                aw = int'($urandom_range(0, N - 1));
                while (!m[aw]) aw = (aw + 1) % N;
                cq = int'($urandom_range(0, int'(l[aw*CW +: CW])));
            end
            run_batch(m, l, aw, cq, 1'b0);
        end

        tick();
        tick();
        chk("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
